// File: rtl/fractal_pkg.sv
// Shared constants and types for the fractal pixel writer slice.
// Colour palette, framebuffer defaults and write-FSM state encoding.
package fractal_pkg;

  localparam int DEFAULT_H_RES = 640;
  localparam int DEFAULT_V_RES = 480;

  localparam logic [11:0] COLOR_BLACK = 12'h000;

  // RGB444 gradient indexed by the low four bits of the iteration count
  localparam logic [11:0] PALETTE [16] = '{
    12'h00F, 12'h02F, 12'h05F, 12'h08F,
    12'h0BF, 12'h0FF, 12'h0FB, 12'h0F8,
    12'h0F4, 12'h4F0, 12'h8F0, 12'hBF0,
    12'hFF0, 12'hFB0, 12'hF60, 12'hF20
  };

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } wr_state_t;

endpackage

// File: rtl/fractal_pixel_fifo.sv
// Synchronous write buffer for {address, colour} entries.
// Power-of-two depth; pointers wrap naturally at DEPTH.
module fractal_pixel_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Storage array; contents are only observed through a valid head entry
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry and status flags
  always_comb begin
    rd_data = mem[rd_ptr];
    full    = (count == (PW+1)'(DEPTH));
    empty   = (count == '0);
  end

endmodule

// File: rtl/fractal_pixel_writer.sv
// Fractal result -> framebuffer writer: colour map, address, buffer, write FSM.
// Optional build macro PIXEL_WRITER_STATS_EN adds the pixels_written counter.
module fractal_pixel_writer
  import fractal_pkg::*;
#(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int ITER_WIDTH  = 11,
  parameter int H_RES       = DEFAULT_H_RES,
  parameter int V_RES       = DEFAULT_V_RES,
  parameter int ADDR_WIDTH  = 19,
  parameter int COLOR_WIDTH = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   data_out_available,
  output logic                   data_out_read,
  input  logic [X_WIDTH-1:0]     x_coord_in,
  input  logic [Y_WIDTH-1:0]     y_coord_in,
  input  logic [ITER_WIDTH-1:0]  iteration_count_in,
  input  logic                   is_in_the_set_in,
  output logic                   fb_write_en,
  output logic [ADDR_WIDTH-1:0]  fb_address,
  output logic [COLOR_WIDTH-1:0] fb_data,
  input  logic                   fb_write_ready,
  output logic                   fifo_full,
  output logic                   frame_done,
  output logic                   drop_error
`ifdef PIXEL_WRITER_STATS_EN
  , output logic [ADDR_WIDTH-1:0] pixels_written
`endif
);

  localparam int ENTRY_W = ADDR_WIDTH + COLOR_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int PROD_W  = Y_WIDTH + 33;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_RES * V_RES - 1);

  wr_state_t              state;
  logic                   capture;
  logic                   in_range;
  logic [ADDR_WIDTH-1:0]  addr_c;
  logic [COLOR_WIDTH-1:0] color_c;
  logic                   s1_push;
  logic [ENTRY_W-1:0]     s1_entry;
  logic                   write_fire;
  logic [ENTRY_W-1:0]     head;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  // Colour map, range check and full-precision linear address
  always_comb begin
    capture  = data_out_read & data_out_available;
    in_range = ($unsigned(32'(x_coord_in)) < $unsigned(H_RES)) &&
               ($unsigned(32'(y_coord_in)) < $unsigned(V_RES));
    addr_c   = ADDR_WIDTH'(PROD_W'(y_coord_in) * PROD_W'(H_RES) + PROD_W'(x_coord_in));
    color_c  = is_in_the_set_in ? COLOR_WIDTH'(COLOR_BLACK)
                                : COLOR_WIDTH'(PALETTE[iteration_count_in[3:0]]);
  end

  // Capture handshake plus stage-1 register; s1_push counts as in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out_read <= 1'b0;
      s1_push       <= 1'b0;
      s1_entry      <= '0;
      drop_error    <= 1'b0;
    end else begin
      data_out_read <= data_out_available & ~data_out_read &
                       ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(s1_push) < (CNT_W+1)'(FIFO_DEPTH));
      s1_push       <= capture & in_range;
      if (capture) s1_entry <= {addr_c, color_c};
      if (capture && !in_range) drop_error <= 1'b1;
    end
  end

  fractal_pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (s1_push),
    .pop     (write_fire),
    .wr_data (s1_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Framebuffer port presents the FIFO head directly, so it stays stable until popped
  always_comb begin
    write_fire = fb_write_en & fb_write_ready;
    fb_address = fb_write_en ? head[ENTRY_W-1:COLOR_WIDTH] : '0;
    fb_data    = fb_write_en ? head[COLOR_WIDTH-1:0] : '0;
  end

  // Write FSM; a same-cycle push keeps WRITE alive so back-to-back writes never bubble
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      fb_write_en <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state       <= ST_WRITE;
            fb_write_en <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (fb_write_ready && fifo_count == CNT_W'(1) && !s1_push) begin
            state       <= ST_IDLE;
            fb_write_en <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          fb_write_en <= 1'b0;
        end
      endcase
    end
  end

  // End-of-frame pulse one cycle after the last pixel's write completes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) frame_done <= 1'b0;
    else          frame_done <= write_fire && (head[ENTRY_W-1:COLOR_WIDTH] == LAST_ADDR);
  end

`ifdef PIXEL_WRITER_STATS_EN
  // Completed-write counter; zero while frame_done pulses, saturating otherwise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixels_written <= '0;
    end else if (write_fire && head[ENTRY_W-1:COLOR_WIDTH] == LAST_ADDR) begin
      pixels_written <= '0;
    end else if (write_fire && pixels_written != '1) begin
      pixels_written <= pixels_written + ADDR_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fractal_pixel_writer.sv
// Scoreboard bench for fractal_pixel_writer with randomized pixel stream.
module tb_fractal_pixel_writer;

  localparam int H = 640;
  localparam int V = 480;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        data_out_available = 1'b0;
  logic        data_out_read;
  logic [9:0]  x_coord_in = '0;
  logic [9:0]  y_coord_in = '0;
  logic [10:0] iteration_count_in = '0;
  logic        is_in_the_set_in = 1'b0;
  logic        fb_write_en;
  logic [18:0] fb_address;
  logic [11:0] fb_data;
  logic        fb_write_ready = 1'b0;
  logic        fifo_full;
  logic        frame_done;
  logic        drop_error;
`ifdef PIXEL_WRITER_STATS_EN
  logic [18:0] pixels_written;
`endif

  fractal_pixel_writer dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .data_out_available (data_out_available),
    .data_out_read      (data_out_read),
    .x_coord_in         (x_coord_in),
    .y_coord_in         (y_coord_in),
    .iteration_count_in (iteration_count_in),
    .is_in_the_set_in   (is_in_the_set_in),
    .fb_write_en        (fb_write_en),
    .fb_address         (fb_address),
    .fb_data            (fb_data),
    .fb_write_ready     (fb_write_ready),
    .fifo_full          (fifo_full),
    .frame_done         (frame_done),
    .drop_error         (drop_error)
`ifdef PIXEL_WRITER_STATS_EN
    , .pixels_written   (pixels_written)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { int addr; int data; } exp_t;

  logic [11:0] pal [16] = '{
    12'h00F, 12'h02F, 12'h05F, 12'h08F, 12'h0BF, 12'h0FF, 12'h0FB, 12'h0F8,
    12'h0F4, 12'h4F0, 12'h8F0, 12'hBF0, 12'hFF0, 12'hFB0, 12'hF60, 12'hF20
  };

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   sent = 0;
  int   captures = 0;
  int   fd_pulses = 0;
  int   stat_model = 0;
  bit   drop_model = 1'b0;
  bit   fd_expect = 1'b0;
  bit   stop_ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops the scoreboard on every completed framebuffer write
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        fd_expect = 1'b0;
      end else begin
        if (frame_done || fd_expect) check("frame_done", int'(frame_done), int'(fd_expect));
        if (frame_done) fd_pulses++;
        fd_expect = 1'b0;
        if (data_out_read && data_out_available) captures++;
        if (fb_write_en && fb_write_ready) begin
          if (sbq.size() == 0) begin
            fail_now("unexpected_write");
          end else begin
            e = sbq.pop_front();
            check("fb_address", int'(fb_address), e.addr);
            check("fb_data", int'(fb_data), e.data);
            fd_expect = (e.addr == H * V - 1);
            stat_model = fd_expect ? 0 : stat_model + 1;
          end
        end
      end
    end
  end

  task automatic start_pixel(input int x, input int y, input int it, input bit s);
    x_coord_in         = 10'(x);
    y_coord_in         = 10'(y);
    iteration_count_in = 11'(it);
    is_in_the_set_in   = s;
    data_out_available = 1'b1;
    sent++;
    if (x < H && y < V) sbq.push_back('{y * H + x, s ? 0 : int'(pal[it % 16])});
    else                drop_model = 1'b1;
  endtask

  task automatic finish_pixel();
    bit got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (data_out_read) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("handshake_timeout");
    @(posedge clock);
    #1 data_out_available = 1'b0;
  endtask

  task automatic send_pixel(input int x, input int y, input int it, input bit s);
    start_pixel(x, y, it, s);
    finish_pixel();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("drain_timeout");
    wait_cycles(3);
  endtask

  // Capture edge -> fb_write_en must rise after exactly two more edges
  task automatic check_latency(input string name);
    @(negedge clock); check({name, "_c0"}, int'(fb_write_en), 0);
    @(negedge clock); check({name, "_c1"}, int'(fb_write_en), 0);
    @(negedge clock); check({name, "_c2"}, int'(fb_write_en), 1);
  endtask

  initial begin
    int rd_cnt;
    int x, y;

    // Reset state
    wait_cycles(3);
    @(negedge clock);
    check("rst_read", int'(data_out_read), 0);
    check("rst_wen", int'(fb_write_en), 0);
    check("rst_addr", int'(fb_address), 0);
    check("rst_data", int'(fb_data), 0);
    check("rst_full", int'(fifo_full), 0);
    check("rst_fd", int'(frame_done), 0);
    check("rst_drop", int'(drop_error), 0);
`ifdef PIXEL_WRITER_STATS_EN
    check("rst_stats", int'(pixels_written), 0);
`endif
    @(posedge clock);
    #1 reset_n = 1'b1;
    wait_cycles(2);

    // Single pixel: addr 1283, PALETTE[5], two-cycle latency
    fb_write_ready = 1'b1;
    send_pixel(3, 2, 5, 1'b0);
    check_latency("t1_latency");
    drain();
`ifdef PIXEL_WRITER_STATS_EN
    check("t1_stats", int'(pixels_written), stat_model);
`endif

    // Last pixel of the frame, in-set
    send_pixel(639, 479, 7, 1'b1);
    drain();
    check("t2_fd_pulses", fd_pulses, 1);

    // Backpressure: four fill the buffer, fifth held ten cycles unread
    fb_write_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_pixel(10 + i, 20, i + 3, 1'b0);
    wait_cycles(3);
    check("t3_full", int'(fifo_full), 1);
    start_pixel(14, 20, 9, 1'b0);
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (data_out_read) rd_cnt++;
    end
    check("t3_read_withheld", rd_cnt, 0);
    check("t3_full_held", int'(fifo_full), 1);
    check("t3_wen_held", int'(fb_write_en), 1);
    check("t3_addr_held", int'(fb_address), sbq[0].addr);
    check("t3_data_held", int'(fb_data), sbq[0].data);
    @(posedge clock);
    #1 fb_write_ready = 1'b1;
    finish_pixel();
    send_pixel(15, 20, 12, 1'b0);
    drain();
    check("t3_full_clear", int'(fifo_full), 0);

    // Out-of-range drop, then normal pixel
    send_pixel(700, 10, 3, 1'b0);
    wait_cycles(4);
    check("t5_drop", int'(drop_error), 1);
    check("t5_no_write", int'(fb_write_en), 0);
    send_pixel(5, 5, 2, 1'b0);
    drain();
    check("t5_drop_sticky", int'(drop_error), 1);

    // Randomized stream with random write backpressure
    stop_ready = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(640, 1023)) : int'($urandom_range(0, 639));
          y = ($urandom_range(0, 15) == 0) ? int'($urandom_range(480, 1023)) : int'($urandom_range(0, 479));
          send_pixel(x, y, int'($urandom_range(0, 2047)), 1'($urandom_range(0, 3) == 0));
          if ($urandom_range(0, 2) == 0) wait_cycles(int'($urandom_range(1, 4)));
        end
        stop_ready = 1'b1;
      end
      begin
        while (!stop_ready) begin
          @(posedge clock);
          #1 fb_write_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    fb_write_ready = 1'b1;
    drain();
    check("rand_drop", int'(drop_error), int'(drop_model));
`ifdef PIXEL_WRITER_STATS_EN
    check("rand_stats", int'(pixels_written), stat_model);
`endif

    // Reset while writing with three entries queued
    fb_write_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_pixel(100 + i, 50, i, 1'b0);
    wait_cycles(3);
    check("t6_wen_before", int'(fb_write_en), 1);
    reset_n = 1'b0;
    #2;
    check("t6_wen_rst", int'(fb_write_en), 0);
    check("t6_full_rst", int'(fifo_full), 0);
    check("t6_drop_rst", int'(drop_error), 0);
    sbq.delete();
    drop_model = 1'b0;
    stat_model = 0;
    wait_cycles(2);
    reset_n = 1'b1;
    fb_write_ready = 1'b1;
    wait_cycles(5);
    check("t6_idle_after", int'(fb_write_en), 0);
`ifdef PIXEL_WRITER_STATS_EN
    check("t6_stats_rst", int'(pixels_written), 0);
`endif
    send_pixel(7, 9, 4, 1'b0);
    check_latency("t6_latency");
    drain();

    check("captures", captures, sent);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
